// File: rtl/pipeline_pkg.sv
// Shared pipeline constants: per-boundary bundle widths, control-bundle field
// offsets and the NOP control word inserted for bubbles.
package pipeline_pkg;

  localparam int unsigned IFID_CTRL_WIDTH  = 2;
  localparam int unsigned IFID_DATA_WIDTH  = 64;
  localparam int unsigned IDEX_CTRL_WIDTH  = 6;
  localparam int unsigned IDEX_DATA_WIDTH  = 96;
  localparam int unsigned EXMEM_CTRL_WIDTH = 4;
  localparam int unsigned EXMEM_DATA_WIDTH = 64;
  localparam int unsigned MEMWB_CTRL_WIDTH = 2;
  localparam int unsigned MEMWB_DATA_WIDTH = 32;

  localparam int unsigned CTRL_REG_WRITE  = 0;
  localparam int unsigned CTRL_MEM_TO_REG = 1;
  localparam int unsigned CTRL_MEM_READ   = 2;
  localparam int unsigned CTRL_MEM_WRITE  = 3;
  localparam int unsigned CTRL_ALU_SRC    = 4;
  localparam int unsigned CTRL_BRANCH     = 5;

  // All-zero control: no register write, no memory access, no branch.
  localparam int unsigned CTRL_MAX_WIDTH = 8;
  localparam logic [CTRL_MAX_WIDTH-1:0] CTRL_NOP = '0;

  function automatic logic [1:0] entry_count(input logic a, input logic b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/pipeline_stage_buffer_entry.sv
// stage_entry: valid-tagged holding register. Clear beats load beats drop;
// the payload is kept when the entry empties so out_data holds its last value.
module stage_entry #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic             drop,
  input  logic [WIDTH-1:0] d,
  output logic             valid,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      q     <= '0;
    end else begin
      if (clear)     valid <= 1'b0;
      else if (load) valid <= 1'b1;
      else if (drop) valid <= 1'b0;
      if (load && !clear) q <= d;
    end
  end

endmodule

// File: rtl/pipeline_stage_buffer.sv
// Elastic interstage buffer: valid/ready handshake, optional skid entry,
// synchronous flush and NOP-forced control on bubbles.
module pipeline_stage_buffer
  import pipeline_pkg::*;
#(
  parameter int unsigned CTRL_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter bit          SKID       = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            occupancy
);

  localparam int unsigned W = CTRL_WIDTH + DATA_WIDTH;

  logic         main_valid, skid_valid;
  logic [W-1:0] main_q, skid_q, main_d;
  logic         accept, fire;
  logic         main_load, main_drop, skid_load, skid_drop;

  assign accept = in_valid & in_ready;
  assign fire   = main_valid & out_ready;

  // With a skid entry, in_ready comes straight from a flop.
  assign in_ready = SKID ? ~skid_valid : (~main_valid | out_ready);

  always_comb begin
    main_load = 1'b0;
    main_drop = 1'b0;
    skid_load = 1'b0;
    skid_drop = 1'b0;
    main_d    = {in_ctrl, in_data};
    if (SKID) begin
      skid_load = accept & main_valid & ~fire;
      skid_drop = skid_valid & fire;
      main_load = fire ? (skid_valid | accept) : (~main_valid & accept);
      if (skid_valid) main_d = skid_q;
    end else begin
      main_load = accept;
    end
    main_drop = fire & ~main_load;
  end

  stage_entry #(.WIDTH(W)) u_main (
    .clock (clock),
    .reset (reset),
    .clear (flush),
    .load  (main_load),
    .drop  (main_drop),
    .d     (main_d),
    .valid (main_valid),
    .q     (main_q)
  );

  generate
    if (SKID) begin : g_skid
      stage_entry #(.WIDTH(W)) u_skid (
        .clock (clock),
        .reset (reset),
        .clear (flush),
        .load  (skid_load),
        .drop  (skid_drop),
        .d     ({in_ctrl, in_data}),
        .valid (skid_valid),
        .q     (skid_q)
      );
    end else begin : g_no_skid
      assign skid_valid = 1'b0;
      assign skid_q     = '0;
    end
  endgenerate

  assign out_valid = main_valid;
  assign out_ctrl  = main_valid ? main_q[W-1 -: CTRL_WIDTH] : CTRL_WIDTH'(CTRL_NOP);
  assign out_data  = main_q[DATA_WIDTH-1:0];
  assign occupancy = entry_count(main_valid, skid_valid);

endmodule
